// File: rtl/rv_pkg.sv
// Shared RV32I control encodings: opcodes, imm_gen select, PC/WB mux codes, FSM states.
// Pure declarations; no latency or flow control.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] EXT_I     = 3'b000;
  localparam logic [2:0] EXT_B     = 3'b001;
  localparam logic [2:0] EXT_J     = 3'b010;
  localparam logic [2:0] EXT_S     = 3'b011;
  localparam logic [2:0] EXT_U     = 3'b100;
  localparam logic [2:0] EXT_SHAMT = 3'b101;
  localparam logic [2:0] EXT_NONE  = 3'b111;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    IC_OP, IC_OPIMM, IC_LUI, IC_AUIPC, IC_JAL, IC_JALR, IC_LOAD,
    IC_STORE, IC_BRANCH, IC_FENCE, IC_SYSTEM, IC_ILLEGAL
  } iclass_e;

endpackage

// File: rtl/rv_op_decode.sv
// Combinational opcode/funct3 -> instruction class and imm_gen select.
// Zero latency, no flow control.
module rv_op_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output iclass_e    iclass,
  output logic [2:0] ext_op
);

  always_comb begin
    iclass = IC_ILLEGAL;
    ext_op = EXT_NONE;
    case (opcode)
      OPC_OPIMM: begin
        iclass = IC_OPIMM;
        ext_op = (funct3 == 3'b001 || funct3 == 3'b101) ? EXT_SHAMT : EXT_I;
      end
      OPC_OP:     iclass = IC_OP;
      OPC_LUI:    begin iclass = IC_LUI;    ext_op = EXT_U; end
      OPC_AUIPC:  begin iclass = IC_AUIPC;  ext_op = EXT_U; end
      OPC_JAL:    begin iclass = IC_JAL;    ext_op = EXT_J; end
      OPC_JALR:   begin iclass = IC_JALR;   ext_op = EXT_I; end
      OPC_LOAD:   begin iclass = IC_LOAD;   ext_op = EXT_I; end
      OPC_STORE:  begin iclass = IC_STORE;  ext_op = EXT_S; end
      OPC_BRANCH: begin iclass = IC_BRANCH; ext_op = EXT_B; end
      OPC_FENCE:  iclass = IC_FENCE;
      // ECALL/EBREAK share funct3=000; CSR forms are outside RV32I
      OPC_SYSTEM: iclass = (funct3 == 3'b000) ? IC_SYSTEM : IC_ILLEGAL;
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB, 3-5 cycles per instruction.
// FETCH and MEM hold mem_req until mem_ready; all strobes drop asynchronously in reset.
module rv_mc_ctrl
  import rv_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic [2:0]  ext_op,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  state,
  output logic        illegal
);

  state_e     state_q, state_d;
  logic [2:0] ext_op_q, ext_op_d;
  logic       illegal_q, illegal_d;
  iclass_e    iclass;
  logic [2:0] dec_ext_op;
  logic       rd_nz;
  logic       imm_form;
  logic       inst_unused;

  assign inst_unused = ^inst[31:15];
  assign rd_nz       = (inst[11:7] != 5'd0);
  assign imm_form    = iclass inside {IC_OPIMM, IC_LUI, IC_AUIPC, IC_JAL,
                                      IC_JALR, IC_LOAD, IC_STORE};

  rv_op_decode u_dec (
    .opcode (inst[6:0]),
    .funct3 (inst[14:12]),
    .iclass (iclass),
    .ext_op (dec_ext_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      ext_op_q  <= EXT_NONE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ext_op_q  <= ext_op_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ext_op_d  = ext_op_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        ext_op_d = dec_ext_op;
        if (iclass == IC_SYSTEM || (iclass == IC_ILLEGAL && TRAP_ON_ILLEGAL))
          state_d = ST_TRAP;
        else
          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (iclass)
          IC_LOAD, IC_STORE:                         state_d = ST_MEM;
          IC_BRANCH, IC_FENCE, IC_ILLEGAL, IC_SYSTEM: state_d = ST_FETCH;
          default:                                   state_d = ST_WB;
        endcase
      end
      ST_MEM:  if (mem_ready) state_d = (iclass == IC_LOAD) ? ST_WB : ST_FETCH;
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
    if (state_d == ST_TRAP) illegal_d = 1'b1;
  end

  // Gated by rst_n so an in-flight request is abandoned without waiting for a clock
  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        ST_EXEC: begin
          alu_src_a = (iclass == IC_AUIPC);
          alu_src_b = imm_form;
          case (iclass)
            IC_BRANCH: begin
              pc_we  = 1'b1;
              pc_sel = br_taken ? PC_IMM : PC_PLUS4;
            end
            IC_FENCE, IC_ILLEGAL: pc_we = 1'b1;
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (iclass == IC_STORE);
          pc_we   = (iclass == IC_STORE) && mem_ready;
        end
        ST_WB: begin
          rf_we  = rd_nz;
          pc_we  = 1'b1;
          wb_sel = (iclass == IC_LOAD) ? WB_MEM :
                   (iclass == IC_JAL || iclass == IC_JALR) ? WB_PC4 : WB_ALU;
          pc_sel = (iclass == IC_JAL)  ? PC_IMM :
                   (iclass == IC_JALR) ? PC_JALR : PC_PLUS4;
        end
        default: ;
      endcase
    end
  end

  assign ext_op  = ext_op_q;
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Self-checking bench for rv_mc_ctrl: directed table, random instruction stream, reset and trap sequences.
`timescale 1ns/1ps
module tb_rv_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic [2:0]  ext_op;
  logic        ir_we, pc_we, rf_we, alu_src_a, alu_src_b, mem_req, mem_we, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;

  rv_mc_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .br_taken(br_taken), .mem_ready(mem_ready),
    .ext_op(ext_op), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .mem_req(mem_req),
    .mem_we(mem_we), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Per-instruction observable summary: cycle of pc_we counted from the first FETCH cycle, etc.
  typedef struct {
    int lat; int ext; int pcsel; int wbsel; int rf; int a; int b; int memreq; int memwe;
  } exp_t;

  typedef struct {
    logic [31:0] in; int fw; int mw; bit br; exp_t e;
  } vec_t;

  vec_t       vt [14];
  logic [6:0] ops [10];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: cycle costs and mux choices straight from the instruction-set rules
  function automatic exp_t model(input logic [31:0] in, input int fw, input int mw, input bit br);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    int rdnz;
    opc  = in[6:0];
    f3   = in[14:12];
    rdnz = (in[11:7] != 5'd0) ? 1 : 0;
    e = '{lat: fw + 4, ext: 7, pcsel: 0, wbsel: 0, rf: 0, a: 0, b: 1, memreq: 0, memwe: 0};
    case (opc)
      7'h13: begin e.ext = (f3 == 3'd1 || f3 == 3'd5) ? 5 : 0; e.rf = rdnz; end
      7'h33: begin e.b = 0; e.rf = rdnz; end
      7'h37: begin e.ext = 4; e.rf = rdnz; end
      7'h17: begin e.ext = 4; e.a = 1; e.rf = rdnz; end
      7'h6F: begin e.ext = 2; e.rf = rdnz; e.pcsel = 1; e.wbsel = 2; end
      7'h67: begin e.ext = 0; e.rf = rdnz; e.pcsel = 2; e.wbsel = 2; end
      7'h03: begin e.ext = 0; e.rf = rdnz; e.wbsel = 1; e.lat = fw + 5 + mw; e.memreq = mw + 1; end
      7'h23: begin e.ext = 3; e.lat = fw + 4 + mw; e.memreq = mw + 1; e.memwe = mw + 1; end
      7'h63: begin e.ext = 1; e.b = 0; e.lat = fw + 3; e.pcsel = br ? 1 : 0; end
      7'h0F: begin e.b = 0; e.lat = fw + 3; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic run_inst(input logic [31:0] in, input int fw, input int mw, input bit br,
                          input exp_t e, input string tag);
    int c = 0, wcnt = 0;
    bit in_fetch = 1'b1, done = 1'b0;
    int pc_cyc = -1, pcsel_v = -1, wbsel_v = -1, rf_cnt = 0, ir_cnt = 0, ir_cyc = -1;
    int a_v = -1, b_v = -1, mreq = 0, mwe = 0, bad_we = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 1) begin inst = in; br_taken = br; end
      if (mem_req) begin
        mem_ready = (wcnt == (in_fetch ? fw : mw));
        wcnt++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (ir_we) begin ir_cnt++; ir_cyc = c; end
      if (mem_req && !in_fetch) begin mreq++; if (mem_we) mwe++; end
      if (mem_req && in_fetch && mem_we) bad_we++;
      if (c == fw + 3) begin a_v = alu_src_a; b_v = alu_src_b; end
      if (rf_we) rf_cnt++;
      if (pc_we) begin pc_cyc = c; pcsel_v = pc_sel; wbsel_v = wb_sel; done = 1'b1; end
      if (ir_we) begin in_fetch = 1'b0; wcnt = 0; end
    end
    check({tag, ".pc_we_cycle"}, pc_cyc, e.lat);
    check({tag, ".ir_we_cycle"}, ir_cyc, fw + 1);
    check({tag, ".ir_we_count"}, ir_cnt, 1);
    check({tag, ".ext_op"}, int'(ext_op), e.ext);
    check({tag, ".pc_sel"}, pcsel_v, e.pcsel);
    check({tag, ".wb_sel"}, wbsel_v, e.wbsel);
    check({tag, ".rf_we_count"}, rf_cnt, e.rf);
    check({tag, ".alu_src_a"}, a_v, e.a);
    check({tag, ".alu_src_b"}, b_v, e.b);
    check({tag, ".mem_req_cycles"}, mreq, e.memreq);
    check({tag, ".mem_we_cycles"}, mwe, e.memwe);
    check({tag, ".fetch_mem_we"}, bad_we, 0);
  endtask

  task automatic do_reset(input string tag);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check({tag, ".rst_state"}, int'(state), 0);
    check({tag, ".rst_ext_op"}, int'(ext_op), 7);
    check({tag, ".rst_illegal"}, int'(illegal), 0);
    check({tag, ".rst_mem_req"}, int'(mem_req), 0);
    check({tag, ".rst_strobes"}, int'({ir_we, pc_we, rf_we, mem_we}), 0);
    rst_n = 1'b1;
  endtask

  task automatic run_trap(input logic [31:0] in, input string tag);
    int ir_cnt = 0, pc_cnt = 0, rf_cnt = 0, mreq_after = 0, ill2 = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) inst = in;
      mem_ready = mem_req ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (c == 2) ill2 = illegal;
      if (ir_we) ir_cnt++;
      if (c > 1 && mem_req) mreq_after++;
      if (pc_we) pc_cnt++;
      if (rf_we) rf_cnt++;
    end
    check({tag, ".illegal_in_decode"}, ill2, 0);
    check({tag, ".illegal"}, int'(illegal), 1);
    check({tag, ".state"}, int'(state), 5);
    check({tag, ".ir_we_count"}, ir_cnt, 1);
    check({tag, ".pc_we_count"}, pc_cnt, 0);
    check({tag, ".rf_we_count"}, rf_cnt, 0);
    check({tag, ".mem_req_after_fetch"}, mreq_after, 0);
    check({tag, ".ext_op"}, int'(ext_op), 7);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{32'h00500093, 0, 0, 1'b0, '{4, 0, 0, 0, 1, 0, 1, 0, 0}};  // addi x1,x0,5
    vt[1]  = '{32'h00500093, 2, 0, 1'b0, '{6, 0, 0, 0, 1, 0, 1, 0, 0}};
    vt[2]  = '{32'h0080A103, 0, 2, 1'b0, '{7, 0, 0, 1, 1, 0, 1, 3, 0}};  // lw x2,8(x1)
    vt[3]  = '{32'h0020A223, 0, 0, 1'b0, '{4, 3, 0, 0, 0, 0, 1, 1, 1}};  // sw x2,4(x1)
    vt[4]  = '{32'h0020A223, 1, 1, 1'b0, '{6, 3, 0, 0, 0, 0, 1, 2, 2}};
    vt[5]  = '{32'h00000463, 0, 0, 1'b1, '{3, 1, 1, 0, 0, 0, 0, 0, 0}};  // beq taken
    vt[6]  = '{32'h00000463, 0, 0, 1'b0, '{3, 1, 0, 0, 0, 0, 0, 0, 0}};  // beq not taken
    vt[7]  = '{32'h010000EF, 0, 0, 1'b0, '{4, 2, 1, 2, 1, 0, 1, 0, 0}};  // jal x1,16
    vt[8]  = '{32'h000100E7, 0, 0, 1'b0, '{4, 0, 2, 2, 1, 0, 1, 0, 0}};  // jalr x1,0(x2)
    vt[9]  = '{32'h00208033, 0, 0, 1'b0, '{4, 7, 0, 0, 0, 0, 0, 0, 0}};  // add x0,x1,x2
    vt[10] = '{32'h123452B7, 0, 0, 1'b0, '{4, 4, 0, 0, 1, 0, 1, 0, 0}};  // lui x5
    vt[11] = '{32'h00001317, 0, 0, 1'b0, '{4, 4, 0, 0, 1, 1, 1, 0, 0}};  // auipc x6
    vt[12] = '{32'h0000000F, 1, 0, 1'b0, '{4, 7, 0, 0, 0, 0, 0, 0, 0}};  // fence
    vt[13] = '{32'h00219193, 0, 0, 1'b0, '{4, 5, 0, 0, 1, 0, 1, 0, 0}};  // slli x3,x3,2
    ops = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h0F};

    do_reset("reset0");

    for (int i = 0; i < 14; i++)
      run_inst(vt[i].in, vt[i].fw, vt[i].mw, vt[i].br, vt[i].e, $sformatf("vec%0d", i));

    // Reset asserted mid-FETCH must drop mem_req before any clock edge
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("midfetch.mem_req_before", int'(mem_req), 1);
    #1 rst_n = 1'b0;
    #1;
    check("midfetch.mem_req_async", int'(mem_req), 0);
    check("midfetch.ext_op", int'(ext_op), 7);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    check("midfetch.state", int'(state), 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] r;
      int fw, mw;
      bit br;
      r      = $urandom;
      r[6:0] = ops[$urandom_range(0, 9)];
      fw     = $urandom_range(0, 2);
      mw     = $urandom_range(0, 2);
      br     = 1'($urandom_range(0, 1));
      run_inst(r, fw, mw, br, model(r, fw, mw, br), $sformatf("rnd%0d_%08h", i, r));
    end

    run_trap(32'h00000073, "ecall");
    do_reset("reset1");
    run_inst(32'h00500093, 0, 0, 1'b0, model(32'h00500093, 0, 0, 1'b0), "after_trap");

    run_trap(32'h00000000, "zero_inst");
    repeat (5) @(negedge clk);
    #1;
    check("sticky.illegal", int'(illegal), 1);
    check("sticky.mem_req", int'(mem_req), 0);
    check("sticky.state", int'(state), 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_mc_ctrl.md
# rv_mc_ctrl

Multi-cycle control unit for the RV32I core. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives the immediate generator's `ExtOp` select, the PC/IR/register-file write strobes, ALU operand muxes and the memory request handshake. Sits between the instruction register and the shared datapath: imm_gen, ALU, register file and single memory port.

## Interface
- `TRAP_ON_ILLEGAL`, default 1: 1 = unknown opcode enters TRAP; 0 = treated as NOP (PC+4, no writes).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inst` in 32: instruction register output; stable from DECODE until next FETCH completes.
- `br_taken` in 1: ALU branch-compare result, valid in EXEC.
- `mem_ready` in 1: memory accepts/completes the access in the cycle it is high while `mem_req`=1.
- `ext_op` out 3: imm_gen select. 000 I, 001 B, 010 J, 011 S, 100 U, 101 shamt, 111 none.
- `ir_we` out 1: load IR from memory read data.
- `pc_we` out 1: PC update strobe.
- `pc_sel` out 2: 00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1.
- `rf_we` out 1: register-file write strobe; never asserted when rd=x0.
- `wb_sel` out 2: 00 ALU, 01 memory data, 10 PC+4.
- `alu_src_a` out 1: 0 rs1, 1 PC.
- `alu_src_b` out 1: 0 rs2, 1 immediate.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: 1 = store; valid only with `mem_req`.
- `state` out 3: current state, for debug.
- `illegal` out 1: sticky; set on TRAP entry, cleared only by reset.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; 6/7 unreachable, recover to FETCH.
- FETCH: `mem_req`=1, `mem_we`=0. Held until `mem_ready`. In the `mem_ready` cycle `ir_we`=1, then → DECODE.
- DECODE: register `ext_op` from `inst[6:0]`:
  - OP-IMM → 000, except funct3 001/101 → 101.
  - LOAD, JALR → 000. BRANCH → 001. JAL → 010. STORE → 011. LUI, AUIPC → 100.
  - OP, FENCE, SYSTEM → 111.
  - `ext_op` holds until the next DECODE.
  - Unknown opcode → TRAP (or NOP path if `TRAP_ON_ILLEGAL`=0); ECALL/EBREAK → TRAP; otherwise → EXEC.
- EXEC routing:
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR → WB.
  - LOAD/STORE → MEM.
  - BRANCH: `pc_we`=1, `pc_sel`=01 if `br_taken` else 00, → FETCH.
  - FENCE: `pc_we`=1, `pc_sel`=00, → FETCH.
  - Operand muxes in EXEC: AUIPC a=1,b=1; OP b=0; all other immediate forms b=1, a=0.
- MEM: `mem_req`=1, `mem_we`=1 for STORE. Held until `mem_ready`.
  - LOAD → WB.
  - STORE: `pc_we`=1, `pc_sel`=00 in the ready cycle, → FETCH.
- WB: `rf_we`=1 (if rd≠0), `pc_we`=1, → FETCH.
  - `wb_sel`: 01 LOAD, 10 JAL/JALR, 00 otherwise.
  - `pc_sel`: 01 JAL, 10 JALR, 00 otherwise.
- TRAP: all strobes 0, `illegal`=1, remains until reset.

## Timing
- Reset values: state=FETCH, `ext_op`=111, `illegal`=0, all strobes and selects 0.
- Reset effects, asynchronous: `mem_req` falls immediately; any in-flight access is abandoned.
- Strobes are combinational from state and registered decode; the state register is the only sequential element besides `ext_op` and `illegal`.
- `mem_ready` may be combinational the same cycle (zero wait); each wait cycle extends FETCH/MEM by one.
- Zero-wait latency in cycles: ALU/LUI/AUIPC/JAL/JALR 4; LOAD 5; STORE 4; BRANCH/FENCE 3.
- `pc_we` and `rf_we` are exactly one cycle per instruction; `ir_we` is exactly one cycle per fetch.
- `mem_ready` outside `mem_req` is ignored.

## Structure
- Shared package `rv_pkg`: opcode constants, `ext_op` encodings (shared with imm_gen), `pc_sel`/`wb_sel` encodings, state enum.
- One sub-module is natural: `rv_op_decode`, a combinational opcode/funct3 → instruction-class and `ext_op` decoder. The FSM lives in `rv_mc_ctrl`.

## Test plan
- Reset mid-FETCH with `mem_req`=1 → `mem_req`=0 immediately; after release state=0, `ext_op`=111.
- `addi x1,x0,5` (0x00500093), zero wait → `ext_op`=000, `alu_src_b`=1, `rf_we`+`pc_we` in cycle 4 only.
- `lw x2,8(x1)` (0x0080A103) with 2 wait cycles in MEM → `mem_we`=0, `wb_sel`=01, `rf_we` at cycle 7.
- `sw x2,4(x1)` (0x0020A223) → `ext_op`=011, `mem_we`=1, `pc_we`+`pc_sel`=00 in the MEM ready cycle, `rf_we` never 1.
- `beq x0,x0,8` (0x00000463) with `br_taken`=1 → `ext_op`=001, `pc_sel`=01 in cycle 3. With `br_taken`=0 → `pc_sel`=00.
- `jal x1,16` (0x010000EF) → `ext_op`=010, `wb_sel`=10, `pc_sel`=01. Then 0x00000000 → TRAP, `illegal`=1 sticky, no further `mem_req`.
